// File: rtl/cva6_vec_pkg.sv
// Shared vector-configuration types and constants for the RVV-enabled 64-bit core.
// Optional feature macro: CVA6_VCFG_FRAC_LMUL_EN (fractional LMUL support).
package cva6_vec_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned VLEN          = 64;
    localparam int unsigned ELEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned MAX_OUTST     = 8;
    localparam int unsigned CNT_W         = $clog2(MAX_OUTST + 1);
    localparam int unsigned VSTART_W      = $clog2(VLEN);

    typedef enum logic [1:0] {
        VSETVLI   = 2'd0,
        VSETIVLI  = 2'd1,
        VSETVL    = 2'd2,
        VSET_RSVD = 2'd3
    } vset_op_e;

    typedef struct packed {
        logic              vill;
        logic [XLEN-10:0]  reserved;
        logic              vma;
        logic              vta;
        logic [2:0]        vsew;
        logic [2:0]        vlmul;
    } vtype_t;

    localparam logic [XLEN-1:0] VTYPE_ILL = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] LMUL_1    = 3'b000;
    localparam logic [2:0] LMUL_2    = 3'b001;
    localparam logic [2:0] LMUL_4    = 3'b010;
    localparam logic [2:0] LMUL_8    = 3'b011;
    localparam logic [2:0] LMUL_RSVD = 3'b100;
    localparam logic [2:0] LMUL_F8   = 3'b101;
    localparam logic [2:0] LMUL_F4   = 3'b110;
    localparam logic [2:0] LMUL_F2   = 3'b111;

    localparam logic [2:0] SEW_8     = 3'b000;
    localparam logic [2:0] SEW_16    = 3'b001;
    localparam logic [2:0] SEW_32    = 3'b010;
    localparam logic [2:0] SEW_64    = 3'b011;

    // Unsigned minimum over the full register width.
    function automatic logic [XLEN-1:0] umin(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        umin = (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cva6_vcfg_unit_chk.sv
// Property checker for the outstanding vector-op counter of cva6_vcfg_unit.
module cva6_vcfg_unit_chk
    import cva6_vec_pkg::*;
(
    input logic             clk_i,
    input logic             rst_i,
    input logic [CNT_W-1:0] cnt_i,
    input logic             vec_issue_i,
    input logic             vec_retire_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    a_cnt_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(vec_issue_i && !vec_retire_i && (cnt_i == CNT_MAX)));

    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(vec_retire_i && !vec_issue_i && (cnt_i == {CNT_W{1'b0}})));

endmodule

// File: rtl/cva6_vlmax_calc.sv
// Combinational VLMAX / legality evaluation for an encoded {vsew, vlmul} pair.
// Shifts only; no divider. Fractional LMUL depends on CVA6_VCFG_FRAC_LMUL_EN.
module cva6_vlmax_calc
    import cva6_vec_pkg::*;
(
    input  logic [2:0]      vsew_i,
    input  logic [2:0]      vlmul_i,
    output logic [XLEN-1:0] vlmax_o,
    output logic            illegal_o
);

    localparam logic [XLEN-1:0] VLEN_X    = XLEN'(VLEN);
    localparam logic [XLEN-1:0] ELEN_X    = XLEN'(ELEN);
    localparam logic [XLEN-1:0] SEW_MIN_X = XLEN'(64'd8);

    logic [XLEN-1:0] sew_s;
    logic [XLEN-1:0] per_lmul1_s;
    logic [XLEN-1:0] vlmax_s;
    logic            illegal_s;
`ifdef CVA6_VCFG_FRAC_LMUL_EN
    logic [3:0]      frac_shift_s;
`endif

    // Derive SEW, VLEN/SEW, VLMAX and the illegal flag from the encoded fields
    always_comb begin
        sew_s       = SEW_MIN_X << vsew_i;
        per_lmul1_s = VLEN_X >> (4'd3 + {1'b0, vsew_i});
        vlmax_s     = '0;
        illegal_s   = 1'b0;
`ifdef CVA6_VCFG_FRAC_LMUL_EN
        frac_shift_s = 4'd0;
`endif
        case (vlmul_i)
            LMUL_1, LMUL_2, LMUL_4, LMUL_8: begin
                vlmax_s = per_lmul1_s << vlmul_i[1:0];
            end
`ifdef CVA6_VCFG_FRAC_LMUL_EN
            LMUL_F8, LMUL_F4, LMUL_F2: begin
                // 101 -> /8, 110 -> /4, 111 -> /2
                frac_shift_s = 4'd8 - {1'b0, vlmul_i};
                vlmax_s      = per_lmul1_s >> frac_shift_s;
                illegal_s    = sew_s > (ELEN_X >> frac_shift_s);
            end
`else
            LMUL_F8, LMUL_F4, LMUL_F2: begin
                illegal_s = 1'b1;
            end
`endif
            default: begin
                illegal_s = 1'b1;
            end
        endcase
        illegal_s = illegal_s | (vsew_i > SEW_64) | (sew_s > ELEN_X) | (vlmax_s == '0);
    end

    assign vlmax_o   = vlmax_s;
    assign illegal_o = illegal_s;

endmodule

// File: rtl/cva6_vcfg_unit.sv
// vset{i}vl{i} execution unit: holds vl/vtype/vstart, drains in-flight vector ops
// before reconfiguring, and writes the new vl back two cycles after acceptance.
// Optional feature macro: CVA6_VCFG_FRAC_LMUL_EN (fractional LMUL support).
module cva6_vcfg_unit
    import cva6_vec_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [1:0]               req_op_i,
    input  logic [XLEN-1:0]          req_avl_i,
    input  logic [XLEN-1:0]          req_vtype_i,
    input  logic                     req_rs1_x0_i,
    input  logic                     req_rd_x0_i,
    input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
    output logic                     resp_valid_o,
    output logic [TRANS_ID_BITS-1:0] resp_trans_id_o,
    output logic [XLEN-1:0]          resp_result_o,
    input  logic                     vec_issue_i,
    input  logic                     vec_retire_i,
    output logic                     vec_busy_o,
    output logic                     vcfg_busy_o,
    output logic [XLEN-1:0]          vl_o,
    output logic [XLEN-1:0]          vtype_o,
    input  logic                     vstart_we_i,
    input  logic [XLEN-1:0]          vstart_wdata_i,
    output logic [XLEN-1:0]          vstart_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, COMPUTE = 2'd2, RESP = 2'd3} vcfg_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

    vcfg_state_e              state_r, state_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [XLEN-1:0]          vl_r, vtype_r, vstart_r;
    vset_op_e                 req_op_r;
    logic [XLEN-1:0]          req_avl_r, req_vtype_r;
    logic                     req_rs1_x0_r, req_rd_x0_r;
    logic [TRANS_ID_BITS-1:0] resp_id_r;
    logic                     resp_valid_r;
    logic [XLEN-1:0]          resp_result_r;
    logic                     accept_s, commit_s;
    logic [XLEN-1:0]          vlmax_s, vl_new_s;
    logic                     calc_ill_s, ill_s;
    vtype_t                   vtype_new_s;

    cva6_vlmax_calc i_vlmax_calc (
        .vsew_i    (req_vtype_r[5:3]),
        .vlmul_i   (req_vtype_r[2:0]),
        .vlmax_o   (vlmax_s),
        .illegal_o (calc_ill_s)
    );

    cva6_vcfg_unit_chk i_chk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cnt_i        (cnt_r),
        .vec_issue_i  (vec_issue_i),
        .vec_retire_i (vec_retire_i)
    );

    // Next-state decode; commit_s marks the COMPUTE exit that updates architectural state
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        commit_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid_i) begin
                    accept_s = 1'b1;
                    state_s  = ((cnt_r != {CNT_W{1'b0}}) || vec_issue_i) ? DRAIN : COMPUTE;
                end else begin
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    state_s = IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = COMPUTE;
                end else begin
                    state_s = DRAIN;
                end
            end
            COMPUTE: begin
                if (flush_i) begin
                    state_s = IDLE;
                end else begin
                    commit_s = 1'b1;
                    state_s  = RESP;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // New vl/vtype from the latched request; rs1=x0,rd=x0 keeps vl unless it no longer fits
    always_comb begin
        ill_s       = calc_ill_s | (|req_vtype_r[XLEN-1:8]);
        vl_new_s    = vl_r;
        vtype_new_s = '0;
        if ((req_op_r == VSETIVLI) || !req_rs1_x0_r) begin
            vl_new_s = umin(req_avl_r, vlmax_s);
        end else if (!req_rd_x0_r) begin
            vl_new_s = vlmax_s;
        end else begin
            vl_new_s = vl_r;
            ill_s    = ill_s | (vl_r > vlmax_s);
        end
        if (ill_s) begin
            vl_new_s    = '0;
            vtype_new_s = vtype_t'(VTYPE_ILL);
        end else begin
            vtype_new_s.vma   = req_vtype_r[7];
            vtype_new_s.vta   = req_vtype_r[6];
            vtype_new_s.vsew  = req_vtype_r[5:3];
            vtype_new_s.vlmul = req_vtype_r[2:0];
        end
    end

    // FSM state, request latch, architectural vl/vtype and writeback registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r       <= IDLE;
            req_op_r      <= VSETVLI;
            req_avl_r     <= '0;
            req_vtype_r   <= '0;
            req_rs1_x0_r  <= 1'b0;
            req_rd_x0_r   <= 1'b0;
            resp_id_r     <= '0;
            vl_r          <= '0;
            vtype_r       <= VTYPE_ILL;
            resp_valid_r  <= 1'b0;
            resp_result_r <= '0;
        end else begin
            state_r      <= state_s;
            resp_valid_r <= commit_s;
            if (accept_s) begin
                req_op_r     <= vset_op_e'(req_op_i);
                req_avl_r    <= req_avl_i;
                req_vtype_r  <= req_vtype_i;
                req_rs1_x0_r <= req_rs1_x0_i;
                req_rd_x0_r  <= req_rd_x0_i;
                resp_id_r    <= req_trans_id_i;
            end
            if (commit_s) begin
                vl_r          <= vl_new_s;
                vtype_r       <= vtype_new_s;
                resp_result_r <= vl_new_s;
            end
        end
    end

    // vstart: cleared by a committing vset, otherwise written by the CSR port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vstart_r <= '0;
        end else if (commit_s) begin
            vstart_r <= '0;
        end else if (vstart_we_i) begin
            vstart_r <= {{(XLEN-VSTART_W){1'b0}}, vstart_wdata_i[VSTART_W-1:0]};
        end
    end

    // Outstanding vector-op counter, saturating at both ends; never flushed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (vec_issue_i && !vec_retire_i && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (vec_retire_i && !vec_issue_i && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign req_ready_o     = (state_r == IDLE);
    assign vcfg_busy_o     = (state_r != IDLE);
    assign vec_busy_o      = (cnt_r != {CNT_W{1'b0}});
    assign resp_valid_o    = resp_valid_r & ~flush_i;
    assign resp_trans_id_o = resp_id_r;
    assign resp_result_o   = resp_result_r;
    assign vl_o            = vl_r;
    assign vtype_o         = vtype_r;
    assign vstart_o        = vstart_r;

endmodule

// File: tb/tb_cva6_vcfg_unit.sv
// Directed, scoreboard-based bench for cva6_vcfg_unit (VLEN=ELEN=64).
// Honors CVA6_VCFG_FRAC_LMUL_EN for the fractional-LMUL expectation.
module tb_cva6_vcfg_unit;
    import cva6_vec_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, req_valid_i, req_ready_o;
    logic [1:0]  req_op_i;
    logic [63:0] req_avl_i, req_vtype_i;
    logic        req_rs1_x0_i, req_rd_x0_i;
    logic [2:0]  req_trans_id_i, resp_trans_id_o;
    logic        resp_valid_o;
    logic [63:0] resp_result_o;
    logic        vec_issue_i, vec_retire_i, vec_busy_o, vcfg_busy_o;
    logic [63:0] vl_o, vtype_o, vstart_wdata_i, vstart_o;
    logic        vstart_we_i;

    localparam logic [63:0] ILL = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] res;
        logic [63:0] vtype;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk_i = ~clk_i;

    cva6_vcfg_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_avl_i(req_avl_i), .req_vtype_i(req_vtype_i), .req_rs1_x0_i(req_rs1_x0_i),
        .req_rd_x0_i(req_rd_x0_i), .req_trans_id_i(req_trans_id_i),
        .resp_valid_o(resp_valid_o), .resp_trans_id_o(resp_trans_id_o), .resp_result_o(resp_result_o),
        .vec_issue_i(vec_issue_i), .vec_retire_i(vec_retire_i), .vec_busy_o(vec_busy_o),
        .vcfg_busy_o(vcfg_busy_o), .vl_o(vl_o), .vtype_o(vtype_o),
        .vstart_we_i(vstart_we_i), .vstart_wdata_i(vstart_wdata_i), .vstart_o(vstart_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge; it is accepted on the following posedge.
    task automatic send(input logic [1:0] op, input logic [63:0] avl, input logic [63:0] vt,
                        input logic rs1x0, input logic rdx0, input logic [2:0] id,
                        input bit push, input logic [63:0] evl, input logic [63:0] evt);
        @(negedge clk_i);
        chk("ready_before_req", {63'd0, req_ready_o}, 64'd1);
        req_op_i = op; req_avl_i = avl; req_vtype_i = vt;
        req_rs1_x0_i = rs1x0; req_rd_x0_i = rdx0; req_trans_id_i = id;
        req_valid_i = 1'b1;
        if (push) sb_q.push_back('{id, evl, evt});
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    // Wait (bounded) for a response, check latency in negedges, pop and compare.
    task automatic wait_resp(input string tag, input int budget, input int exp_lat);
        int   lat  = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && lat < budget) begin
            @(negedge clk_i);
            lat++;
            if (resp_valid_o) seen = 1'b1;
        end
        chk({tag, "_resp_seen"}, {63'd0, seen}, 64'd1);
        if (seen) begin
            chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            chk({tag, "_sb_nonempty"}, {63'd0, (sb_q.size() != 0)}, 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({tag, "_id"}, {61'd0, resp_trans_id_o}, {61'd0, e.id});
                chk({tag, "_result"}, resp_result_o, e.res);
                chk({tag, "_vl"}, vl_o, e.res);
                chk({tag, "_vtype"}, vtype_o, e.vtype);
            end
            @(negedge clk_i);
            chk({tag, "_one_cycle"}, {63'd0, resp_valid_o}, 64'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; req_op_i = 2'd0;
        req_avl_i = 64'd0; req_vtype_i = 64'd0; req_rs1_x0_i = 1'b0; req_rd_x0_i = 1'b0;
        req_trans_id_i = 3'd0; vec_issue_i = 1'b0; vec_retire_i = 1'b0;
        vstart_we_i = 1'b0; vstart_wdata_i = 64'd0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_vl", vl_o, 64'd0);
        chk("rst_vtype", vtype_o, ILL);
        chk("rst_vstart", vstart_o, 64'd0);
        chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
        chk("rst_vec_busy", {63'd0, vec_busy_o}, 64'd0);
        chk("rst_vcfg_busy", {63'd0, vcfg_busy_o}, 64'd0);

        // e32 m1, avl=5 -> VLMAX=2
        send(2'd0, 64'd5, 64'h10, 1'b0, 1'b0, 3'd3, 1'b1, 64'd2, 64'h10);
        wait_resp("e32m1", 10, 2);
        // e8 m8, avl=100 -> VLMAX=64
        send(2'd0, 64'd100, 64'h03, 1'b0, 1'b0, 3'd4, 1'b1, 64'd64, 64'h03);
        wait_resp("e8m8", 10, 2);
        // VSETIVLI uimm=3, e16 m1 (rs1_x0 flag ignored)
        send(2'd1, 64'd3, 64'h08, 1'b1, 1'b0, 3'd5, 1'b1, 64'd3, 64'h08);
        wait_resp("ivli_e16", 10, 2);
        // AVL above 2^32 must compare at full width: vl = VLMAX = 8
        send(2'd2, 64'h0000_0001_0000_0003, 64'h00, 1'b0, 1'b0, 3'd6, 1'b1, 64'd8, 64'h00);
        wait_resp("wide_avl", 10, 2);
        // rs1=x0, rd!=x0, e8 m2 -> vl=VLMAX=16
        send(2'd0, 64'd0, 64'h01, 1'b1, 1'b0, 3'd7, 1'b1, 64'd16, 64'h01);
        wait_resp("x0_vlmax", 10, 2);
        // rs1=x0, rd=x0, e64 m1: old vl 16 > VLMAX 1 -> vill
        send(2'd0, 64'd0, 64'h18, 1'b1, 1'b1, 3'd0, 1'b1, 64'd0, ILL);
        wait_resp("keep_vl_ill", 10, 2);
        // vsew=4 -> vill
        send(2'd0, 64'd4, 64'h20, 1'b0, 1'b0, 3'd1, 1'b1, 64'd0, ILL);
        wait_resp("vsew4", 10, 2);
        // reserved vtype bit 8 set -> vill
        send(2'd2, 64'd4, 64'h100, 1'b0, 1'b0, 3'd2, 1'b1, 64'd0, ILL);
        wait_resp("rsvd_bit", 10, 2);
        // e8 mf2
`ifdef CVA6_VCFG_FRAC_LMUL_EN
        send(2'd0, 64'd10, 64'h07, 1'b0, 1'b0, 3'd3, 1'b1, 64'd4, 64'h07);
`else
        send(2'd0, 64'd10, 64'h07, 1'b0, 1'b0, 3'd3, 1'b1, 64'd0, ILL);
`endif
        wait_resp("e8mf2", 10, 2);
        // e64 mf2 is illegal in every build
        send(2'd0, 64'd10, 64'h1F, 1'b0, 1'b0, 3'd4, 1'b1, 64'd0, ILL);
        wait_resp("e64mf2", 10, 2);

        // Drain: two dispatched ops, then a request that must wait
        @(negedge clk_i) vec_issue_i = 1'b1;
        @(negedge clk_i) vec_issue_i = 1'b1;
        @(negedge clk_i) vec_issue_i = 1'b0;
        chk("drain_vec_busy", {63'd0, vec_busy_o}, 64'd1);
        send(2'd0, 64'd5, 64'h10, 1'b0, 1'b0, 3'd5, 1'b1, 64'd2, 64'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("drain_vcfg_busy", {63'd0, vcfg_busy_o}, 64'd1);
            chk("drain_no_resp", {63'd0, resp_valid_o}, 64'd0);
        end
        vec_retire_i = 1'b1;
        @(negedge clk_i) vec_retire_i = 1'b1;
        @(negedge clk_i) vec_retire_i = 1'b0;
        chk("drain_cnt_zero", {63'd0, vec_busy_o}, 64'd0);
        chk("drain_still_busy", {63'd0, vcfg_busy_o}, 64'd1);
        wait_resp("drain", 10, 2);

        // Flush in COMPUTE: no response, no architectural change
        send(2'd0, 64'd7, 64'h03, 1'b0, 1'b0, 3'd6, 1'b0, 64'd0, 64'd0);
        @(negedge clk_i) flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("flush_no_resp", {63'd0, resp_valid_o}, 64'd0);
        end
        chk("flush_vl", vl_o, 64'd2);
        chk("flush_vtype", vtype_o, 64'h10);
        chk("flush_ready", {63'd0, req_ready_o}, 64'd1);

        // vstart CSR write keeps the low 6 bits
        @(negedge clk_i) begin vstart_we_i = 1'b1; vstart_wdata_i = 64'hFFFF; end
        @(negedge clk_i) vstart_we_i = 1'b0;
        chk("vstart_write", vstart_o, 64'h3F);
        // A CSR write coinciding with the COMPUTE exit loses to the clear
        send(2'd0, 64'd8, 64'h00, 1'b0, 1'b0, 3'd7, 1'b1, 64'd8, 64'h00);
        @(negedge clk_i) begin vstart_we_i = 1'b1; vstart_wdata_i = 64'd5; end
        @(posedge clk_i);
        #1 vstart_we_i = 1'b0;
        wait_resp("vstart_race", 10, 1);
        chk("vstart_cleared", vstart_o, 64'd0);

        // Reset while held in DRAIN
        @(negedge clk_i) vec_issue_i = 1'b1;
        @(negedge clk_i) vec_issue_i = 1'b0;
        send(2'd0, 64'd3, 64'h08, 1'b0, 1'b0, 3'd1, 1'b0, 64'd0, 64'd0);
        @(negedge clk_i);
        chk("rstdrain_busy", {63'd0, vcfg_busy_o}, 64'd1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rstdrain_vl", vl_o, 64'd0);
        chk("rstdrain_vtype", vtype_o, ILL);
        chk("rstdrain_vec_busy", {63'd0, vec_busy_o}, 64'd0);
        chk("rstdrain_vcfg_busy", {63'd0, vcfg_busy_o}, 64'd0);
        chk("rstdrain_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rstdrain_resp", {63'd0, resp_valid_o}, 64'd0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
